// File: rtl/fifo_to_axis_if.sv
// -----------------------------------------------------------------------------
// fifo_to_axis_if.sv
// Bus bundles for the fifo_to_axis unpacker.
//   fifo_to_axis_rd_if   : first-word-fall-through read side of the SRAM queue
//     din[201:0]  packed word {payload[191:0], cnt[4:0], kind[2:0], last, rsvd}
//     din_valid   din holds a word
//     din_rd      pop strobe (word consumed when din_valid && din_rd)
//   fifo_to_axis_axis_if : 256-bit AXI4-Stream beat toward the output port
//     tvalid/tready, tdata[255:0], tstrb[31:0], tuser[127:0], tlast
// The master modport drives the payload, the slave modport returns the
// flow-control signal.
// -----------------------------------------------------------------------------
interface fifo_to_axis_rd_if;
    logic [201:0] din;
    logic         din_valid;
    logic         din_rd;

    modport master (output din, output din_valid, input  din_rd);
    modport slave  (input  din, input  din_valid, output din_rd);
endinterface

interface fifo_to_axis_axis_if;
    logic         tvalid;
    logic         tready;
    logic [255:0] tdata;
    logic [31:0]  tstrb;
    logic [127:0] tuser;
    logic         tlast;

    modport master (output tvalid, output tdata, output tstrb, output tuser,
                    output tlast, input tready);
    modport slave  (input  tvalid, input  tdata, input  tstrb, input  tuser,
                    input  tlast, output tready);
endinterface

// File: rtl/fifo_to_axis.sv
// -----------------------------------------------------------------------------
// fifo_to_axis.sv
// Unpacks 202-bit cropped words (192-bit payload + control) read back from the
// SRAM output queue into 256-bit AXI4-Stream beats. Each packet is one header
// word (tuser) followed by data words where every four words carry three beats.
//
// Ports:
//   i_clk      block clock
//   i_rst_n    asynchronous active-low reset
//   s_rd       fifo_to_axis_rd_if.slave   (din, din_valid, din_rd)
//   m_axis     fifo_to_axis_axis_if.master (tvalid, tready, tdata, tstrb,
//                                           tuser, tlast)
//   o_fmt_err  sticky format error
//
// Build option:
//   FIFO_TO_AXIS_FORMAT_CHECK_EN  when defined, the word kind sequence is
//   checked; a bad word sets o_fmt_err, is dropped, and all words up to the
//   next header are discarded. When undefined the FSM advances on position
//   only and o_fmt_err is tied low.
// -----------------------------------------------------------------------------
module fifo_to_axis #(
    parameter int TDATA_WIDTH        = 32,
    parameter int TUSER_WIDTH        = 16,
    parameter int CROPPED_DATA_WIDTH = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fifo_to_axis_rd_if.slave     s_rd,
    fifo_to_axis_axis_if.master  m_axis,
    output logic                 o_fmt_err
);

    localparam int BEAT_W = 8 * TDATA_WIDTH;
    localparam int USER_W = 8 * TUSER_WIDTH;
    localparam int PL_W   = 8 * CROPPED_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_HDR = 3'd0,
        ST_W1  = 3'd1,
        ST_W2  = 3'd2,
        ST_W3  = 3'd3,
        ST_W4  = 3'd4
    } state_t;

    // Last-beat strobes: cnt valid bytes, cnt==0 means a full beat.
    function automatic logic [31:0] strb_from_cnt(input logic [4:0] cnt);
        if (cnt == 5'd0) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << cnt) - 32'd1;
        end
    endfunction

    state_t              r_state;
    logic [PL_W-1:0]     r_res;
    logic                r_tvalid;
    logic [BEAT_W-1:0]   r_tdata;
    logic [31:0]         r_tstrb;
    logic [USER_W-1:0]   r_tuser;
    logic                r_tlast;

    logic [PL_W-1:0]     w_payload;
    logic [4:0]          w_cnt;
    logic                w_last;
    logic                w_rd;
    logic                w_pop;
    logic                w_err;
    logic                w_emit;
    logic                w_beat_last;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_load_tuser;
    state_t              w_next_state;
    logic [PL_W-1:0]     w_next_res;

    assign w_payload = s_rd.din[201:10];
    assign w_cnt     = s_rd.din[9:5];
    assign w_last    = s_rd.din[1];

    // Pop whenever the output register is free or being emptied this cycle;
    // words that emit nothing still follow this rule.
    assign w_rd        = !r_tvalid || m_axis.tready;
    assign w_pop       = s_rd.din_valid && w_rd;
    assign s_rd.din_rd = w_rd;

`ifdef FIFO_TO_AXIS_FORMAT_CHECK_EN
    logic [2:0] w_kind;
    logic       w_unused_rsvd;
    logic       r_fmt_err;

    assign w_kind        = s_rd.din[4:2];
    assign w_unused_rsvd = s_rd.din[0];

    // Word kind that is legal in each FSM position.
    function automatic logic [2:0] expected_kind(input state_t st);
        case (st)
            ST_HDR:  return 3'd0;
            ST_W1:   return 3'd1;
            ST_W2:   return 3'd2;
            ST_W3:   return 3'd3;
            ST_W4:   return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    assign w_err = w_pop && ((w_kind != expected_kind(r_state)) ||
                             (w_last && ((r_state == ST_HDR) || (r_state == ST_W1))));

    // Sticky format error flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fmt_err <= 1'b0;
        end else if (w_err) begin
            r_fmt_err <= 1'b1;
        end else begin
            r_fmt_err <= r_fmt_err;
        end
    end

    assign o_fmt_err = r_fmt_err;
`else
    logic [3:0] w_unused_ctl;

    assign w_unused_ctl = {s_rd.din[4:2], s_rd.din[0]};
    assign w_err        = 1'b0;
    assign o_fmt_err    = 1'b0;
`endif

    // Next-state, residual and beat assembly for the word being consumed.
    always_comb begin
        w_emit       = 1'b0;
        w_beat_last  = 1'b0;
        w_beat       = {BEAT_W{1'b0}};
        w_load_tuser = 1'b0;
        w_next_state = r_state;
        w_next_res   = r_res;
        if (w_pop && !w_err) begin
            case (r_state)
                ST_HDR: begin
                    w_load_tuser = 1'b1;
                    w_next_state = ST_W1;
                end
                ST_W1: begin
                    w_next_res   = w_payload;
                    w_next_state = ST_W2;
                end
                ST_W2: begin
                    w_emit = 1'b1;
                    w_beat = {w_payload[63:0], r_res[191:0]};
                    if (w_last) begin
                        w_beat_last  = 1'b1;
                        w_next_state = ST_HDR;
                    end else begin
                        w_next_res   = {64'd0, w_payload[191:64]};
                        w_next_state = ST_W3;
                    end
                end
                ST_W3: begin
                    w_emit = 1'b1;
                    w_beat = {w_payload[127:0], r_res[127:0]};
                    if (w_last) begin
                        w_beat_last  = 1'b1;
                        w_next_state = ST_HDR;
                    end else begin
                        w_next_res   = {128'd0, w_payload[191:128]};
                        w_next_state = ST_W4;
                    end
                end
                ST_W4: begin
                    w_emit = 1'b1;
                    w_beat = {w_payload, r_res[63:0]};
                    if (w_last) begin
                        w_beat_last  = 1'b1;
                        w_next_state = ST_HDR;
                    end else begin
                        w_next_state = ST_W1;
                    end
                end
                default: begin
                    w_next_state = ST_HDR;
                end
            endcase
        end else if (w_pop) begin
            // Malformed word: drop it and resynchronise on the next header.
            w_next_state = ST_HDR;
        end else begin
            w_next_state = r_state;
        end
    end

    // FSM, residual, tuser and registered stream outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_HDR;
            r_res    <= {PL_W{1'b0}};
            r_tvalid <= 1'b0;
            r_tdata  <= {BEAT_W{1'b0}};
            r_tstrb  <= 32'd0;
            r_tuser  <= {USER_W{1'b0}};
            r_tlast  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_res   <= w_next_res;
            if (w_load_tuser) begin
                r_tuser <= w_payload[USER_W-1:0];
            end else begin
                r_tuser <= r_tuser;
            end
            if (w_emit) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_beat;
                r_tstrb  <= w_beat_last ? strb_from_cnt(w_cnt) : 32'hFFFF_FFFF;
                r_tlast  <= w_beat_last;
            end else if (m_axis.tready) begin
                r_tvalid <= 1'b0;
            end else begin
                r_tvalid <= r_tvalid;
            end
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tstrb  = r_tstrb;
    assign m_axis.tuser  = r_tuser;
    assign m_axis.tlast  = r_tlast;

endmodule
